// File: rtl/imem_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
// addr_legal() treats any address that is misaligned or beyond the memory depth as illegal.
package imem_fetch_pkg;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_VALID = 2'd1,
        ST_ERR   = 2'd2
    } fetch_state_t;

    localparam int unsigned IMEM_WORDS_DEF = 1024;
    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;

    // Comparing word indices keeps the range check free of overflow for depths up to 2^30 words.
    function automatic logic addr_legal(input logic [31:0] addr, input int unsigned words);
        return (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < words);
    endfunction

endpackage

// File: rtl/imem_lat_cnt.sv
// Loadable down-counter that measures the memory access window; reload value MEM_LAT-1.
// The count stops at zero and zero_o stays high until the next load.
module imem_lat_cnt #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    input  logic en_i,
    output logic zero_o
);
    localparam int unsigned    CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0]  LOAD_VAL = CW'(MEM_LAT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= LOAD_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: holds imem_addr for MEM_LAT cycles, then offers {pc,instr} until decode accepts.
// Redirects override sequential flow; IMEM_FETCH_PERF_EN adds saturating fetch/stall counters.
module imem_fetch_ctrl
    import imem_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic        fetch_err_o
`ifdef IMEM_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_stall_cnt_o
`endif
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic         if_valid_q;
    logic [31:0]  if_pc_q;
    logic [31:0]  if_instr_q;
    logic         fetch_err_q;

    logic         pc_load_d;
    logic [31:0]  pc_next_d;
    logic         pc_legal;
    logic         cnt_zero;

    // A redirect takes precedence over pc+4, even when it coincides with a completed transfer.
    always_comb begin
        pc_load_d = 1'b0;
        pc_next_d = pc_q;
        if (redirect_valid_i) begin
            pc_load_d = 1'b1;
            pc_next_d = redirect_pc_i;
        end else if (if_valid_q && if_ready_i) begin
            pc_load_d = 1'b1;
            pc_next_d = pc_q + 32'd4;
        end
    end

    assign pc_legal = addr_legal(pc_next_d, IMEM_WORDS);

    imem_lat_cnt #(
        .MEM_LAT (MEM_LAT)
    ) u_lat_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (pc_load_d),
        .en_i    (state_q == ST_WAIT),
        .zero_o  (cnt_zero)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_WAIT;
            pc_q        <= RESET_PC;
            if_valid_q  <= 1'b0;
            if_pc_q     <= '0;
            if_instr_q  <= '0;
            fetch_err_q <= 1'b0;
        end else if (pc_load_d) begin
            pc_q       <= pc_next_d;
            if_valid_q <= 1'b0;
            if (pc_legal) begin
                state_q <= ST_WAIT;
            end else begin
                state_q     <= ST_ERR;
                fetch_err_q <= 1'b1;
            end
        end else if ((state_q == ST_WAIT) && cnt_zero) begin
            if_instr_q <= imem_instr_i;
            if_pc_q    <= pc_q;
            if_valid_q <= 1'b1;
            state_q    <= ST_VALID;
        end
    end

    assign imem_addr_o = pc_q;
    assign if_valid_o  = if_valid_q;
    assign if_pc_o     = if_pc_q;
    assign if_instr_o  = if_instr_q;
    assign fetch_err_o = fetch_err_q;

`ifdef IMEM_FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (if_valid_q && if_ready_i && (perf_fetch_q != 32'hFFFF_FFFF)) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (if_valid_q && !if_ready_i && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt_o = perf_fetch_q;
    assign perf_stall_cnt_o = perf_stall_q;
`endif

endmodule
